noc_vc_fifo: RTL and testbench

Parametrised multi-channel (virtual-channel) flit buffer for the PageRank NoC router input ports: NUM_VC independent circular queues share one storage array, each with its own pointers, occupancy counter and full/almost-full/empty/almost-empty status. It replaces the single-queue input buffer and adds per-VC occupancy, programmable thresholds and optional sticky error reporting. Writes are gated by the flit valid bit (data_in[0]). Read data is show-ahead.

---
 rtl/noc_fifo_pkg.sv | 13 +
 rtl/vc_fifo_mem.sv | 28 ++
 rtl/noc_vc_fifo.sv | 166 ++++++++++++++++
 tb/tb_noc_vc_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_fifo_pkg.sv
// Shared constants and helpers for the NoC virtual-channel flit buffer.
package noc_fifo_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int ADDWIDTH_DEF = 3;
    localparam int NUM_VC_DEF   = 2;
    localparam int VALID_BIT    = 0;

    function automatic int vcw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_fifo_mem.sv
// Flit storage shared by all VCs: one write port, one asynchronous read port.
module vc_fifo_mem
    import noc_fifo_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int AW      = 4,
    parameter int ENTRIES = 16
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses past the last VC exist only when NUM_VC is not a power of two.
    assign rdata = (int'(raddr) < ENTRIES) ? mem[raddr] : '0;

endmodule

// File: rtl/noc_vc_fifo.sv
// Multi-VC flit buffer with per-VC pointers, occupancy and status flags.
// Define NOC_FIFO_ERR_EN to add sticky overflow/underflow error flags.
module noc_vc_fifo
    import noc_fifo_pkg::*;
#(
    parameter  int WIDTH     = WIDTH_DEF,
    parameter  int ADDWIDTH  = ADDWIDTH_DEF,
    parameter  int NUM_VC    = NUM_VC_DEF,
    parameter  int AF_THRESH = 1,
    parameter  int AE_THRESH = 1,
    localparam int VCW       = vcw(NUM_VC),
    localparam int CW        = ADDWIDTH + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [VCW-1:0]       wr_vc,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 rd_en,
    input  logic [VCW-1:0]       rd_vc,
    output logic [WIDTH-1:0]     data_out,
    output logic [NUM_VC-1:0]    full,
    output logic [NUM_VC-1:0]    almost_full,
    output logic [NUM_VC-1:0]    empty,
    output logic [NUM_VC-1:0]    almost_empty,
`ifdef NOC_FIFO_ERR_EN
    input  logic                 err_clr,
    output logic [NUM_VC-1:0]    overflow_err,
    output logic [NUM_VC-1:0]    underflow_err,
`endif
    output logic [NUM_VC*CW-1:0] count
);

    localparam int DEPTH = 2 ** ADDWIDTH;

    logic [ADDWIDTH-1:0] head [NUM_VC];
    logic [ADDWIDTH-1:0] tail [NUM_VC];
    logic [CW-1:0]       cnt  [NUM_VC];

    logic [NUM_VC-1:0]   wr_hit;
    logic [NUM_VC-1:0]   rd_hit;
    logic [NUM_VC-1:0]   wr_acc;
    logic [NUM_VC-1:0]   rd_acc;
    logic [ADDWIDTH-1:0] wr_ptr;
    logic [ADDWIDTH-1:0] rd_ptr;
    logic                rd_sel_empty;
    logic [WIDTH-1:0]    mem_rdata;

    always_comb begin
        full         = '0;
        almost_full  = '0;
        empty        = '0;
        almost_empty = '0;
        count        = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full[v]  = (cnt[v] == CW'(DEPTH));
            empty[v] = (cnt[v] == '0);
            almost_full[v] =
                ((DEPTH - int'(cnt[v])) <= AF_THRESH) && !full[v];
            almost_empty[v] =
                (int'(cnt[v]) <= AE_THRESH) && !empty[v];
            count[v*CW +: CW] = cnt[v];
        end
    end

    // Out-of-range VC numbers match no channel, so they are never accepted.
    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        wr_acc = '0;
        rd_acc = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_hit[v] = wr_en && data_in[VALID_BIT] && (wr_vc == VCW'(v));
            rd_hit[v] = rd_en && (rd_vc == VCW'(v));
            wr_acc[v] = wr_hit[v] && !full[v];
            rd_acc[v] = rd_hit[v] && !empty[v];
        end
    end

    always_comb begin
        wr_ptr       = '0;
        rd_ptr       = '0;
        rd_sel_empty = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_vc == VCW'(v)) begin
                wr_ptr = head[v];
            end
            if (rd_vc == VCW'(v)) begin
                rd_ptr       = tail[v];
                rd_sel_empty = empty[v];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                head[v] <= '0;
                tail[v] <= '0;
                cnt[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_acc[v]) begin
                    head[v] <= head[v] + ADDWIDTH'(1);
                end
                if (rd_acc[v]) begin
                    tail[v] <= tail[v] + ADDWIDTH'(1);
                end
                unique case ({wr_acc[v], rd_acc[v]})
                    2'b10:   cnt[v] <= cnt[v] + CW'(1);
                    2'b01:   cnt[v] <= cnt[v] - CW'(1);
                    default: cnt[v] <= cnt[v];
                endcase
            end
        end
    end

    vc_fifo_mem #(
        .WIDTH   (WIDTH),
        .AW      (VCW + ADDWIDTH),
        .ENTRIES (NUM_VC * DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    ((|wr_acc) && reset),
        .waddr ({wr_vc, wr_ptr}),
        .wdata (data_in),
        .raddr ({rd_vc, rd_ptr}),
        .rdata (mem_rdata)
    );

    assign data_out = rd_sel_empty ? '0 : mem_rdata;

`ifdef NOC_FIFO_ERR_EN
    logic              wr_in;
    logic              rd_in;
    logic [NUM_VC-1:0] ovf_set;
    logic [NUM_VC-1:0] unf_set;

    assign wr_in = int'(wr_vc) < NUM_VC;
    assign rd_in = int'(rd_vc) < NUM_VC;

    // Stray VC numbers are charged to VC0.
    always_comb begin
        ovf_set = '0;
        unf_set = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            ovf_set[v] = wr_hit[v] && full[v];
            unf_set[v] = rd_hit[v] && empty[v];
        end
        ovf_set[0] = ovf_set[0] || (wr_en && data_in[VALID_BIT] && !wr_in);
        unf_set[0] = unf_set[0] || (rd_en && !rd_in);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_err  <= '0;
            underflow_err <= '0;
        end else begin
            overflow_err  <= ovf_set | (overflow_err & {NUM_VC{!err_clr}});
            underflow_err <= unf_set | (underflow_err & {NUM_VC{!err_clr}});
        end
    end
`endif

endmodule

// File: tb/tb_noc_vc_fifo.sv
// Bench for noc_vc_fifo: vector table plus scoreboard of queued flits.
module tb_noc_vc_fifo;

    typedef struct {
        logic        we;
        logic        wvc;
        logic [15:0] din;
        logic        re;
        logic        rvc;
        logic [3:0]  c0;
        logic [3:0]  c1;
        logic [1:0]  emp;
        logic [1:0]  ful;
        logic [1:0]  af;
        logic [1:0]  ae;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [0:0]  wr_vc;
    logic [15:0] data_in;
    logic        rd_en;
    logic [0:0]  rd_vc;
    logic [15:0] data_out;
    logic [1:0]  full;
    logic [1:0]  almost_full;
    logic [1:0]  empty;
    logic [1:0]  almost_empty;
    logic [7:0]  count;
`ifdef NOC_FIFO_ERR_EN
    logic        err_clr;
    logic [1:0]  overflow_err;
    logic [1:0]  underflow_err;
`endif

    noc_vc_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_vc        (wr_vc),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .rd_vc        (rd_vc),
        .data_out     (data_out),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
`ifdef NOC_FIFO_ERR_EN
        .err_clr      (err_clr),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err),
`endif
        .count        (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb0 [$];
    logic [15:0] sb1 [$];
    vec_t tv [21];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic wvc, input logic [15:0] din,
        input logic re, input logic rvc, input logic [3:0] c0,
        input logic [3:0] c1, input logic [1:0] emp, input logic [1:0] ful,
        input logic [1:0] af, input logic [1:0] ae);
        vec_t t;
        t.we = we; t.wvc = wvc; t.din = din; t.re = re; t.rvc = rvc;
        t.c0 = c0; t.c1 = c1; t.emp = emp; t.ful = ful; t.af = af; t.ae = ae;
        return t;
    endfunction

    function automatic int qsize(input logic v);
        return v ? sb1.size() : sb0.size();
    endfunction

    function automatic logic [15:0] qfront(input logic v);
        if (v) return (sb1.size() > 0) ? sb1[0] : 16'h0;
        return (sb0.size() > 0) ? sb0[0] : 16'h0;
    endfunction

    task automatic idle();
        wr_en = 1'b0; wr_vc = '0; data_in = '0; rd_en = 1'b0; rd_vc = '0;
    endtask

    initial begin
        vec_t        t;
        logic        wacc;
        logic        racc;
        logic [15:0] popped;

        tv[0]  = mk(1, 0, 16'h0011, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 2'b01);
        tv[1]  = mk(1, 0, 16'h0021, 0, 0, 2, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tv[2]  = mk(1, 0, 16'h0031, 0, 0, 3, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tv[3]  = mk(1, 0, 16'h0041, 0, 0, 4, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tv[4]  = mk(1, 0, 16'h0051, 0, 0, 5, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tv[5]  = mk(1, 0, 16'h0061, 0, 0, 6, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        tv[6]  = mk(1, 0, 16'h0071, 0, 0, 7, 0, 2'b10, 2'b00, 2'b01, 2'b00);
        tv[7]  = mk(1, 0, 16'h0081, 0, 0, 8, 0, 2'b10, 2'b01, 2'b00, 2'b00);
        tv[8]  = mk(1, 0, 16'h0091, 1, 0, 7, 0, 2'b10, 2'b00, 2'b01, 2'b00);
        tv[9]  = mk(1, 0, 16'h00A0, 0, 0, 7, 0, 2'b10, 2'b00, 2'b01, 2'b00);
        tv[10] = mk(1, 1, 16'h0113, 1, 0, 6, 1, 2'b00, 2'b00, 2'b00, 2'b10);
        tv[11] = mk(0, 0, 16'h0000, 1, 0, 5, 1, 2'b00, 2'b00, 2'b00, 2'b10);
        tv[12] = mk(0, 0, 16'h0000, 1, 0, 4, 1, 2'b00, 2'b00, 2'b00, 2'b10);
        tv[13] = mk(0, 0, 16'h0000, 1, 0, 3, 1, 2'b00, 2'b00, 2'b00, 2'b10);
        tv[14] = mk(0, 0, 16'h0000, 1, 0, 2, 1, 2'b00, 2'b00, 2'b00, 2'b10);
        tv[15] = mk(0, 0, 16'h0000, 1, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b11);
        tv[16] = mk(1, 0, 16'h0093, 1, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b11);
        tv[17] = mk(0, 0, 16'h0000, 1, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b10);
        tv[18] = mk(1, 0, 16'h00B1, 1, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b11);
        tv[19] = mk(0, 0, 16'h0000, 1, 1, 1, 0, 2'b10, 2'b00, 2'b00, 2'b01);
        tv[20] = mk(0, 0, 16'h0000, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00);

`ifdef NOC_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        // Reset held two cycles with a valid write pending.
        reset = 1'b0;
        idle();
        wr_en = 1'b1;
        data_in = 16'h0003;
        repeat (2) @(posedge clk);
        #1;
        chk("rst count", count, 8'h00);
        chk("rst empty", empty, 2'b11);
        chk("rst full", full, 2'b00);
        chk("rst af", almost_full, 2'b00);
        chk("rst ae", almost_empty, 2'b00);
        chk("rst dout", data_out, 16'h0000);
`ifdef NOC_FIFO_ERR_EN
        chk("rst ovf", overflow_err, 2'b00);
        chk("rst unf", underflow_err, 2'b00);
`endif
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst no write", count, 8'h00);

        for (int i = 0; i < 21; i++) begin
            t = tv[i];
            wr_en = t.we; wr_vc = t.wvc; data_in = t.din;
            rd_en = t.re; rd_vc = t.rvc;
            #1;
            chk($sformatf("v%0d dout", i), data_out, qfront(t.rvc));
            wacc = t.we && t.din[0] && (qsize(t.wvc) < 8);
            racc = t.re && (qsize(t.rvc) > 0);
            @(posedge clk);
            if (racc) begin
                if (t.rvc) popped = sb1.pop_front();
                else       popped = sb0.pop_front();
            end
            if (wacc) begin
                if (t.wvc) sb1.push_back(t.din);
                else       sb0.push_back(t.din);
            end
            #1;
            chk($sformatf("v%0d count", i), count, {t.c1, t.c0});
            chk($sformatf("v%0d empty", i), empty, t.emp);
            chk($sformatf("v%0d full", i), full, t.ful);
            chk($sformatf("v%0d af", i), almost_full, t.af);
            chk($sformatf("v%0d ae", i), almost_empty, t.ae);
        end
        idle();

`ifdef NOC_FIFO_ERR_EN
        chk("ovf sticky", overflow_err, 2'b01);
        chk("unf sticky", underflow_err, 2'b01);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("ovf clr", overflow_err, 2'b00);
        chk("unf clr", underflow_err, 2'b00);
`endif

        // Three flits queued, then a single-cycle reset discards them.
        wr_en = 1'b1;
        wr_vc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_in = 16'h0201 + 16'(2 * k);
            @(posedge clk);
            #1;
        end
        idle();
        chk("mid count3", count, 8'h03);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("mid empty", empty, 2'b11);
        chk("mid count0", count, 8'h00);
        chk("mid dout", data_out, 16'h0000);
        sb0.delete();

        wr_en = 1'b1;
        data_in = 16'h0301;
        @(posedge clk);
        #1;
        idle();
        chk("post dout", data_out, 16'h0301);
        chk("post count", count, 8'h01);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        idle();
        chk("post empty", empty, 2'b11);
        chk("post dout0", data_out, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
